// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared definitions for the multi-port register file slice.
//   state_t        - control state encoding (ST_INIT clear sweep, ST_RUN normal)
//   DEF_*          - default widths/counts used as parameter defaults elsewhere
package regfile_mp_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle between a register-file client and regfile_mp.
//   we/waddr/wdata      - write ports (port i at slice i), committed on the clock edge
//   re/raddr -> rdata   - read ports, combinational data
//   pend_set/pend_addr  - mark one entry pending (producer issued)
//   busy                - per read port: addressed entry pending and not written this cycle
//   init_done           - clear sweep finished
//   state               - current control state, exported for observation
//
// Handshake: there is no valid/ready pair. Every write/pend_set with its enable
// high is taken unconditionally on the rising edge while the block is in RUN and
// dropped while it is in INIT or reset; the client must gate its traffic on
// init_done. Reads are purely combinational and always answer in the same cycle.
interface regfile_mp_if import regfile_mp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) ();

  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic [NUM_RD-1:0]        busy;
  logic                     init_done;
  state_t                   state;

  modport master (
    output we, waddr, wdata, re, raddr, pend_set, pend_addr,
    input  rdata, busy, init_done, state
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, pend_set, pend_addr,
    output rdata, busy, init_done, state
  );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// regfile_rd_port: one read port of the register file.
//   active  - block is in RUN and not in reset; outputs are zero otherwise
//   re/raddr- this port's enable and address
//   we/waddr/wdata - all write ports, used for same-cycle bypass
//   stored  - array contents at raddr
//   pending - pending bit of the entry at raddr
//   rdata   - read data (zero, bypassed write data, or stored value)
//   busy    - entry pending and not being written this cycle
module regfile_rd_port import regfile_mp_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     active,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        stored,
  input  logic                     pending,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy
);

  logic              hit;
  logic [DATA_W-1:0] byp_data;

  // Ascending scan so the highest-index matching write port ends up selected,
  // matching the priority used when the array itself is written.
  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
        hit      = 1'b1;
        byp_data = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    busy  = 1'b0;
    if (active && re && !(ZERO_REG && (raddr == '0))) begin
      rdata = hit ? byp_data : stored;
      // A write landing this cycle resolves the hazard, so it hides busy.
      busy  = pending && !hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-bit scoreboard.
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset; restarts the clear sweep
//   bus       - regfile_mp_if slave: write ports, read ports, pend_set,
//               busy, init_done and the exported control state
// After reset the array is cleared one entry per cycle (INIT); then RUN
// accepts writes and pend_set. Higher write-port index wins on conflicts.
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic                init_done;
  logic [DEPTH-1:0]    pending;
  logic [DEPTH-1:0]    pending_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                run;
  logic [NUM_RD*DATA_W-1:0] rdata_w;
  logic [NUM_RD-1:0]   busy_w;

  // Reset gates everything combinationally so outputs are quiet during rst.
  assign run = (state == ST_RUN) && !rst;

  // Control FSM: clear sweep counter, then park in RUN until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      idx       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
            idx       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state     <= ST_INIT;
          idx       <= '0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Array storage has no reset; zeros come only from the sweep. Ports are
  // visited in ascending order so the highest index wins on a shared address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[idx] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (bus.we[i] && !(ZERO_REG && (bus.waddr[i*ADDR_W +: ADDR_W] == '0))) begin
            mem[bus.waddr[i*ADDR_W +: ADDR_W]] <= bus.wdata[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Writes clear first, then pend_set is applied so a new producer issuing
  // in the same cycle as the old result returns keeps the entry pending.
  always_comb begin
    pending_nxt = pending;
    if (run) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.we[i]) begin
          pending_nxt[bus.waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
        end
      end
      if (bus.pend_set && !(ZERO_REG && (bus.pend_addr == '0))) begin
        pending_nxt[bus.pend_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[j*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .active  (run),
      .re      (bus.re[j]),
      .raddr   (ra),
      .we      (bus.we),
      .waddr   (bus.waddr),
      .wdata   (bus.wdata),
      .stored  (mem[ra]),
      .pending (pending[ra]),
      .rdata   (rdata_w[j*DATA_W +: DATA_W]),
      .busy    (busy_w[j])
    );
  end

  assign bus.rdata     = rdata_w;
  assign bus.busy      = busy_w;
  assign bus.init_done = init_done;
  assign bus.state     = state;

endmodule
